// File: rtl/alu_vector_sequencer_if.sv
// alu_vector_sequencer_if: operand/result bus between the self-test sequencer and the 4-bit ALU
interface alu_vector_sequencer_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_cout_add;
  logic       alu_cout_sub;
  logic       alu_ovf_add;
  logic       alu_ovf_sub;
  modport master (
    output alu_a, alu_b, alu_cin, alu_op,
    input  alu_result, alu_cout_add, alu_cout_sub, alu_ovf_add, alu_ovf_sub
  );
  modport slave (
    input  alu_a, alu_b, alu_cin, alu_op,
    output alu_result, alu_cout_add, alu_cout_sub, alu_ovf_add, alu_ovf_sub
  );
endinterface

// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer: walks every vector of the enabled ALU ops and checks results against a golden model
module alu_vector_sequencer #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op_en,
  alu_vector_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 err_valid,
  output logic [11:0]          first_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [10:0] idx, idx_n;
  logic [3:0] en, higher;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0] sum, dif;
  logic cin, go, last, bad;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
  endfunction
  // idx = {op, a, b, cin}; the ALU pins are the index register itself
  assign a = idx[8:5];
  assign b = idx[4:1];
  assign cin = idx[0];
  assign bus.alu_a = a;
  assign bus.alu_b = b;
  assign bus.alu_cin = cin;
  assign bus.alu_op = {1'b0, idx[10:9]};
  assign go = start && (state == IDLE || state == DONE);
  assign higher = en & (4'b1110 << idx[10:9]);
  assign last = (&idx[8:0]) && !(|higher);
  assign idx_n = (&idx[8:0]) ? {lowest(higher), 9'b0} : idx + 11'd1;
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  // 4-state compare so X/Z on a checked ALU output counts as a failure
  always_comb begin
    bad = idx[10:9] == 2'd0 ? {bus.alu_result, bus.alu_cout_add, bus.alu_ovf_add} !==
            {sum[WIDTH-1:0], sum[WIDTH], (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])} :
          idx[10:9] == 2'd1 ? {bus.alu_result, bus.alu_cout_sub, bus.alu_ovf_sub} !==
            {dif[WIDTH-1:0], dif[WIDTH], (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1])} :
          idx[10:9] == 2'd2 ? bus.alu_result !== (a & b) : bus.alu_result !== (a | b);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = go ? (|op_en ? SETTLE : DONE) :
              state == SETTLE ? CHECK :
              state == CHECK ? (last ? DONE : SETTLE) : state;
  end
  always_comb begin
    busy = state == SETTLE || state == CHECK;
    done = state == DONE;
    pass = done && err_count == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      en <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
    end else if (go) begin
      en <= op_en;
      err_count <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
      if (|op_en) idx <= {lowest(op_en), 9'b0};
    end else if (state == CHECK) begin
      if (bad) err_count <= err_count + ERR_W'(1);
      if (bad && !err_valid) begin
        err_valid <= 1'b1;
        first_err <= {idx, 1'b0};
      end
      if (!last) idx <= idx_n;
    end
  end
endmodule

// File: tb/tb_alu_vector_sequencer.sv
// tb_alu_vector_sequencer: directed and random self-test runs against a fault-injectable ALU model
module tb_alu_vector_sequencer;
  logic clk = 1'b0;
  logic reset, start;
  logic [3:0] op_en;
  logic busy, done, pass, err_valid;
  logic [11:0] err_count, first_err;
  int fault = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] v;
  alu_vector_sequencer_if bus();
  alu_vector_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_en(op_en), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_valid(err_valid), .first_err(first_err)
  );
  always #5 clk = ~clk;
  // returns {result[3:0], cout_add, cout_sub, ovf_add, ovf_sub}; f=1 sticks ADD bit0 low, f=2 zeroes SUB borrow
  function automatic logic [7:0] alu_model(input int op, input int a, input int b, input int c, input int f);
    int sa, sb, s, d;
    logic [3:0] r;
    logic ca, cs, oa, os;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    s = a + b + c;
    d = a - b - c;
    ca = s > 15;
    cs = a < b + c;
    oa = (sa + sb + c) > 7 || (sa + sb + c) < -8;
    os = (sa - sb - c) > 7 || (sa - sb - c) < -8;
    r = op == 0 ? 4'(s) : op == 1 ? 4'(d) : op == 2 ? 4'(a & b) : 4'(a | b);
    if (f == 1 && op == 0) r[0] = 1'b0;
    if (f == 2 && op == 1) cs = 1'b0;
    return {r, ca, cs, oa, os};
  endfunction
  always_comb begin
    v = alu_model(int'(bus.alu_op[1:0]), int'(bus.alu_a), int'(bus.alu_b), int'(bus.alu_cin), fault);
    bus.alu_result = v[7:4];
    bus.alu_cout_add = v[3];
    bus.alu_cout_sub = v[2];
    bus.alu_ovf_add = v[1];
    bus.alu_ovf_sub = v[0];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] en, input int f, input int mid);
    int n, ee, ef, cyc;
    logic ev;
    logic [7:0] g, x, m, seen;
    n = 0; ee = 0; ef = 0; ev = 1'b0;
    for (int op = 0; op < 4; op++)
      if (en[op])
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
              n++;
              g = alu_model(op, a, b, c, 0);
              x = alu_model(op, a, b, c, f);
              m = op == 0 ? 8'hFA : op == 1 ? 8'hF5 : 8'hF0;
              if (((g ^ x) & m) != 8'h00) begin
                ee++;
                if (!ev) begin
                  ev = 1'b1;
                  ef = (op << 10) | (a << 6) | (b << 2) | (c << 1);
                end
              end
            end
    fault = f;
    @(posedge clk); #1;
    op_en = en;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    seen = '0;
    chk("busy_after_start", {31'b0, busy}, {31'b0, en != 4'b0});
    while (!done && cyc < 5000) begin
      if (busy) seen[bus.alu_op] = 1'b1;
      if (mid != 0 && cyc == mid) begin
        start = 1'b1;
        op_en = ~en;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("run_cycles", cyc, n == 0 ? 0 : 2 * n);
    chk("err_count", {20'b0, err_count}, ee);
    chk("pass", {31'b0, pass}, {31'b0, ee == 0});
    chk("err_valid", {31'b0, err_valid}, {31'b0, ev});
    chk("first_err", {20'b0, first_err}, ef);
    chk("ops_driven", {24'b0, seen}, {28'b0, en});
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_ctrl", {28'b0, busy, done, pass, err_valid}, 0);
    chk("reset_counts", {8'b0, err_count, first_err}, 0);
    chk("reset_bus", {20'b0, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; op_en = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    op_en = 4'hF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (98) @(posedge clk);
    #1;
    chk("midrun_busy", {31'b0, busy}, 1);
    do_reset();
    run(4'hF, 0, 0);
    run(4'hF, 1, 0);
    run(4'b0100, 0, 0);
    do_reset();
    run(4'b0000, 0, 0);
    run(4'b0010, 2, 0);
    run(4'b0001, 1, 100);
    run(4'b0001, 0, 0);
    repeat (3) run(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
